// File: rtl/alu_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: command codes, chaining
// predicate and sequencer state encoding.
package alu_pkg;

    typedef logic [3:0] alu_cmd_t;

    localparam alu_cmd_t ALU_AND   = 4'd0;
    localparam alu_cmd_t ALU_XOR   = 4'd1;
    localparam alu_cmd_t ALU_OR    = 4'd2;
    localparam alu_cmd_t ALU_LSL   = 4'd3;
    localparam alu_cmd_t ALU_LSR   = 4'd4;
    localparam alu_cmd_t ALU_ADD   = 4'd5;
    localparam alu_cmd_t ALU_SUB   = 4'd6;
    localparam alu_cmd_t ALU_PASSA = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Commands whose shift/carry bit ripples from one byte slice to the next
    function automatic logic is_chain(alu_cmd_t c);
        return (c == ALU_LSL) || (c == ALU_LSR) || (c == ALU_ADD) || (c == ALU_SUB);
    endfunction

    function automatic logic is_legal(alu_cmd_t c);
        return ~c[3];
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Byte-wide link between the sequencer (master) and the shared 8-bit ALU (slave).
interface alu_seq_if;

    alu_pkg::alu_cmd_t alu_cmd;
    logic [7:0]        alu_in_a;
    logic [7:0]        alu_in_b;
    logic              alu_cin;
    logic [7:0]        alu_rslt;
    logic              alu_cout;

    modport master (
        output alu_cmd, alu_in_a, alu_in_b, alu_cin,
        input  alu_rslt, alu_cout
    );

    modport slave (
        input  alu_cmd, alu_in_a, alu_in_b, alu_cin,
        output alu_rslt, alu_cout
    );

endinterface

// File: rtl/alu_seq.sv
// Feeds one NBYTES-wide operation through the shared 8-bit ALU a byte per cycle,
// chaining the shift/carry bit and assembling the wide result.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int unsigned NBYTES = 4,
    localparam int unsigned W      = 8 * NBYTES,
    localparam int unsigned IW     = $clog2(NBYTES)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  alu_cmd_t     cmd,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         carry_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result,
    output logic         carry_out,
    alu_seq_if.master    alu
);

    seq_state_t    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] cnt_q, cnt_d;
    alu_cmd_t      cmd_q, cmd_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [W-1:0]  result_q, result_d;
    logic          carry_out_q, carry_out_d;
    alu_cmd_t      alu_cmd_q, alu_cmd_d;
    logic [7:0]    alu_a_q, alu_a_d;
    logic [7:0]    alu_b_q, alu_b_d;
    logic          alu_cin_q, alu_cin_d;

    function automatic logic [7:0] byte_of(logic [W-1:0] v, logic [IW-1:0] i);
        return v[8*i +: 8];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            cmd_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            alu_cmd_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            alu_cmd_q   <= alu_cmd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
        end
    end

    // ALU drive registers are loaded one edge ahead of the byte they present
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        alu_cmd_d   = '0;
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_cin_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cmd_d  = cmd;
                    a_d    = op_a;
                    b_d    = op_b;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    if (is_legal(cmd)) begin
                        state_d   = RUN;
                        idx_d     = (cmd == ALU_LSR) ? IW'(NBYTES - 1) : '0;
                        alu_cmd_d = cmd;
                        alu_a_d   = byte_of(op_a, idx_d);
                        alu_b_d   = byte_of(op_b, idx_d);
                        alu_cin_d = is_chain(cmd) & carry_in;
                    end else begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        err_d       = 1'b1;
                        result_d    = '0;
                        carry_out_d = 1'b0;
                    end
                end
            end
            RUN: begin
                for (int unsigned k = 0; k < NBYTES; k++) begin
                    if (idx_q == IW'(k)) result_d[8*k +: 8] = alu.alu_rslt;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IW'(NBYTES - 1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    carry_out_d = is_chain(cmd_q) & alu.alu_cout;
                end else begin
                    idx_d     = (cmd_q == ALU_LSR) ? idx_q - 1'b1 : idx_q + 1'b1;
                    alu_cmd_d = cmd_q;
                    alu_a_d   = byte_of(a_q, idx_d);
                    alu_b_d   = byte_of(b_q, idx_d);
                    alu_cin_d = is_chain(cmd_q) & alu.alu_cout;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign result       = result_q;
    assign carry_out    = carry_out_q;
    assign alu.alu_cmd  = alu_cmd_q;
    assign alu.alu_in_a = alu_a_q;
    assign alu.alu_in_b = alu_b_q;
    assign alu.alu_cin  = alu_cin_q;

endmodule
